// File: rtl/rename_pkg.sv
// Shared rename-stage constants and tag/pointer types.
// Pointers carry one extra wrap bit above the tag width.
package rename_pkg;

  localparam int NUM_AREGS    = 32;
  localparam int NUM_PREGS    = 64;
  localparam int RENAME_WIDTH = 2;
  localparam int COMMIT_WIDTH = 2;
  localparam int PREG_W       = $clog2(NUM_PREGS);
  localparam int AREG_W       = $clog2(NUM_AREGS);
  localparam int RETIRE_W     = $clog2(RENAME_WIDTH * COMMIT_WIDTH) + 1;

  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [PREG_W:0]   ptr_t;

endpackage

// File: rtl/preg_free_list_if.sv
// Allocation, release, retire and flush signals of the physical-register free list.
interface preg_free_list_if;
  import rename_pkg::*;

  logic [RENAME_WIDTH-1:0]        alloc_req;
  logic                           alloc_ready;
  logic [RENAME_WIDTH*PREG_W-1:0] alloc_preg;
  logic [COMMIT_WIDTH-1:0]        free_valid;
  logic [COMMIT_WIDTH*PREG_W-1:0] free_preg;
  logic [RETIRE_W-1:0]            retire_cnt;
  logic                           flush;
  ptr_t                           free_count;
  logic                           overflow_err;

  modport master (
    output alloc_req, free_valid, free_preg, retire_cnt, flush,
    input  alloc_ready, alloc_preg, free_count, overflow_err
  );

  modport slave (
    input  alloc_req, free_valid, free_preg, retire_cnt, flush,
    output alloc_ready, alloc_preg, free_count, overflow_err
  );

endinterface

// File: rtl/popcount_prefix.sv
// Exclusive prefix popcounts and total popcount of an N-bit vector.
module popcount_prefix #(
  parameter int N  = 2,
  parameter int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]         vec,
  output logic [N-1:0][CW-1:0] prefix,
  output logic [CW-1:0]        total
);

  always_comb begin
    prefix = '0;
    total  = '0;
    for (int i = 0; i < N; i++) begin
      prefix[i] = total;
      total     = total + CW'(vec[i]);
    end
  end

endmodule

// File: rtl/preg_free_list.sv
// Circular FIFO of free physical register tags: multi-wide allocate at the head,
// multi-wide release at the tail, and a retired head that flush rewinds to.
module preg_free_list
  import rename_pkg::*;
(
  input logic             clk,
  input logic             rst,
  preg_free_list_if.slave bus
);

  localparam int ACNT_W = $clog2(RENAME_WIDTH + 1);
  localparam int FCNT_W = $clog2(COMMIT_WIDTH + 1);

  ptr_t head_reg, head_next;
  ptr_t tail_reg, tail_next;
  ptr_t rhead_reg, rhead_next;
  logic overflow_reg, overflow_next;

  ptr_t free_count, space, in_flight, push_cnt;
  logic alloc_ready, fire, push_err, retire_err;

  logic [RENAME_WIDTH-1:0][ACNT_W-1:0] alloc_pfx;
  logic [ACNT_W-1:0]                   alloc_total;
  logic [COMMIT_WIDTH-1:0][FCNT_W-1:0] free_pfx;
  logic [FCNT_W-1:0]                   free_total;

  logic [COMMIT_WIDTH-1:0] push_ok;
  preg_t                   wr_idx [COMMIT_WIDTH];
  preg_t                   mem    [NUM_PREGS];

  popcount_prefix #(.N(RENAME_WIDTH), .CW(ACNT_W)) u_alloc_pc (
    .vec    (bus.alloc_req),
    .prefix (alloc_pfx),
    .total  (alloc_total)
  );

  popcount_prefix #(.N(COMMIT_WIDTH), .CW(FCNT_W)) u_free_pc (
    .vec    (bus.free_valid),
    .prefix (free_pfx),
    .total  (free_total)
  );

  always_comb begin
    free_count  = tail_reg - head_reg;
    alloc_ready = free_count >= ptr_t'(RENAME_WIDTH);
    fire        = (|bus.alloc_req) && alloc_ready && !bus.flush;

    // Pushes beyond the remaining space are dropped; the tag population is broken anyway.
    space    = ptr_t'(NUM_PREGS) - free_count;
    push_err = ptr_t'(free_total) > space;
    push_cnt = push_err ? space : ptr_t'(free_total);

    in_flight  = head_reg - rhead_reg;
    retire_err = ptr_t'(bus.retire_cnt) > in_flight;
    rhead_next = retire_err ? head_reg : rhead_reg + ptr_t'(bus.retire_cnt);

    if (bus.flush)
      head_next = rhead_next;
    else if (fire)
      head_next = head_reg + ptr_t'(alloc_total);
    else
      head_next = head_reg;

    tail_next     = tail_reg + push_cnt;
    overflow_next = overflow_reg | push_err | retire_err;
  end

  assign bus.alloc_ready  = alloc_ready;
  assign bus.free_count   = free_count;
  assign bus.overflow_err = overflow_reg;

  // Requesting slots are compacted so a gap in alloc_req does not burn a tag.
  for (genvar gi = 0; gi < RENAME_WIDTH; gi++) begin : g_alloc
    preg_t rd_idx;
    assign rd_idx = head_reg[PREG_W-1:0] + preg_t'(alloc_pfx[gi]);
    assign bus.alloc_preg[gi*PREG_W +: PREG_W] = mem[rd_idx];
  end

  for (genvar gi = 0; gi < COMMIT_WIDTH; gi++) begin : g_free
    assign wr_idx[gi]  = tail_reg[PREG_W-1:0] + preg_t'(free_pfx[gi]);
    assign push_ok[gi] = bus.free_valid[gi] && (ptr_t'(free_pfx[gi]) < space);
  end

  for (genvar gi = 0; gi < NUM_PREGS; gi++) begin : g_entry
    localparam preg_t RESET_VAL =
      (gi < NUM_PREGS - NUM_AREGS) ? preg_t'(NUM_AREGS + gi) : '0;
    preg_t entry_reg, entry_next;
    logic  entry_we;

    always_comb begin
      entry_we   = 1'b0;
      entry_next = entry_reg;
      for (int j = 0; j < COMMIT_WIDTH; j++) begin
        if (push_ok[j] && wr_idx[j] == preg_t'(gi)) begin
          entry_we   = 1'b1;
          entry_next = bus.free_preg[j*PREG_W +: PREG_W];
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        entry_reg <= RESET_VAL;
      else if (entry_we)
        entry_reg <= entry_next;
    end

    assign mem[gi] = entry_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_reg     <= '0;
      rhead_reg    <= '0;
      tail_reg     <= ptr_t'(NUM_PREGS - NUM_AREGS);
      overflow_reg <= 1'b0;
    end else begin
      head_reg     <= head_next;
      rhead_reg    <= rhead_next;
      tail_reg     <= tail_next;
      overflow_reg <= overflow_next;
    end
  end

endmodule

// File: tb/tb_preg_free_list.sv
// Directed table plus hand sequences for the physical-register free list.
module tb_preg_free_list;
  import rename_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  preg_free_list_if bus ();

  preg_free_list dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [1:0] req;
    logic [1:0] fv;
    int         fp0;
    int         fp1;
    int         rc;
    logic       fl;
    int         e_cnt;
    int         e_s0;   // -1: slot not checked
    int         e_s1;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic [1:0] req, input logic [1:0] fv,
                      input int fp0, input int fp1, input int rc, input logic fl);
    @(negedge clk);
    bus.alloc_req  = req;
    bus.free_valid = fv;
    bus.free_preg  = {preg_t'(fp1), preg_t'(fp0)};
    bus.retire_cnt = RETIRE_W'(rc);
    bus.flush      = fl;
    #1;
  endtask

  function automatic int slot0();
    return int'(bus.alloc_preg[0 +: PREG_W]);
  endfunction

  function automatic int slot1();
    return int'(bus.alloc_preg[PREG_W +: PREG_W]);
  endfunction

  task automatic do_reset();
    rst            = 1'b1;
    bus.alloc_req  = '0;
    bus.free_valid = '0;
    bus.free_preg  = '0;
    bus.retire_cnt = '0;
    bus.flush      = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int q [$];
    int prev0, prev1, t0, t1;
    logic [1:0] fv;

    vecs[0]  = '{2'b00, 2'b00, 0, 0, 0, 1'b0, 32, -1, -1};
    vecs[1]  = '{2'b11, 2'b00, 0, 0, 0, 1'b0, 32, 32, 33};
    vecs[2]  = '{2'b00, 2'b00, 0, 0, 0, 1'b0, 30, -1, -1};
    vecs[3]  = '{2'b10, 2'b00, 0, 0, 0, 1'b0, 30, -1, 34};
    vecs[4]  = '{2'b11, 2'b00, 0, 0, 0, 1'b0, 29, 35, 36};
    vecs[5]  = '{2'b01, 2'b00, 0, 0, 0, 1'b0, 27, 37, -1};
    vecs[6]  = '{2'b11, 2'b00, 0, 0, 2, 1'b1, 26, -1, -1};
    vecs[7]  = '{2'b11, 2'b00, 0, 0, 0, 1'b0, 30, 34, 35};
    vecs[8]  = '{2'b11, 2'b11, 3, 4, 0, 1'b0, 28, 36, 37};
    vecs[9]  = '{2'b00, 2'b00, 0, 0, 0, 1'b0, 28, -1, -1};
    vecs[10] = '{2'b11, 2'b00, 0, 0, 0, 1'b0, 28, 38, 39};
    vecs[11] = '{2'b00, 2'b00, 0, 0, 0, 1'b0, 26, -1, -1};

    // Table: basic allocation, gaps, retire+flush, simultaneous alloc/free
    do_reset();
    check("reset_count", int'(bus.free_count), 32);
    check("reset_ready", int'(bus.alloc_ready), 1);
    check("reset_ovf", int'(bus.overflow_err), 0);
    for (int i = 0; i < 12; i++) begin
      step(vecs[i].req, vecs[i].fv, vecs[i].fp0, vecs[i].fp1, vecs[i].rc, vecs[i].fl);
      $display("vec %0d req=%b fv=%b fl=%b count=%0d s0=%0d s1=%0d",
               i, vecs[i].req, vecs[i].fv, vecs[i].fl, bus.free_count, slot0(), slot1());
      check($sformatf("vec%0d_count", i), int'(bus.free_count), vecs[i].e_cnt);
      check($sformatf("vec%0d_ready", i), int'(bus.alloc_ready), 1);
      check($sformatf("vec%0d_ovf", i), int'(bus.overflow_err), 0);
      if (vecs[i].e_s0 >= 0) check($sformatf("vec%0d_s0", i), slot0(), vecs[i].e_s0);
      if (vecs[i].e_s1 >= 0) check($sformatf("vec%0d_s1", i), slot1(), vecs[i].e_s1);
    end

    // Drain to one tag, all-or-nothing grant, refill via release
    do_reset();
    for (int c = 0; c < 15; c++) begin
      step(2'b11, 2'b00, 0, 0, 0, 1'b0);
      check("drain_s0", slot0(), 32 + 2 * c);
      check("drain_s1", slot1(), 33 + 2 * c);
    end
    step(2'b01, 2'b00, 0, 0, 0, 1'b0);
    check("drain_last_s0", slot0(), 62);
    check("drain_last_count", int'(bus.free_count), 2);
    step(2'b01, 2'b00, 0, 0, 0, 1'b0);
    check("one_left_ready", int'(bus.alloc_ready), 0);
    check("one_left_count", int'(bus.free_count), 1);
    step(2'b00, 2'b00, 0, 0, 0, 1'b0);
    check("no_grant_count", int'(bus.free_count), 1);
    step(2'b00, 2'b01, 5, 0, 0, 1'b0);
    check("free_same_cycle_ready", int'(bus.alloc_ready), 0);
    step(2'b11, 2'b00, 0, 0, 0, 1'b0);
    check("refill_ready", int'(bus.alloc_ready), 1);
    check("refill_count", int'(bus.free_count), 2);
    check("refill_s0", slot0(), 63);
    check("refill_s1", slot1(), 5);
    step(2'b00, 2'b00, 0, 0, 0, 1'b0);
    check("empty_count", int'(bus.free_count), 0);
    check("empty_ready", int'(bus.alloc_ready), 0);

    // Over-retire saturates at head and is flagged; async reset clears the flag
    do_reset();
    step(2'b11, 2'b00, 0, 0, 0, 1'b0);
    step(2'b00, 2'b00, 0, 0, 3, 1'b0);
    check("ovret_before", int'(bus.overflow_err), 0);
    step(2'b00, 2'b00, 0, 0, 0, 1'b1);
    check("ovret_set", int'(bus.overflow_err), 1);
    step(2'b11, 2'b00, 0, 0, 0, 1'b0);
    check("ovret_flush_count", int'(bus.free_count), 30);
    check("ovret_s0", slot0(), 34);
    check("ovret_s1", slot1(), 35);
    check("ovret_sticky", int'(bus.overflow_err), 1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_ovf", int'(bus.overflow_err), 0);
    check("async_rst_count", int'(bus.free_count), 32);
    rst = 1'b0;

    // Push overflow: fill to 64 then one more push
    do_reset();
    for (int c = 0; c < 16; c++) begin
      step(2'b00, 2'b11, 2 * c, 2 * c + 1, 0, 1'b0);
      check("fill_count", int'(bus.free_count), 32 + 2 * c);
    end
    step(2'b00, 2'b01, 7, 0, 0, 1'b0);
    check("full_count", int'(bus.free_count), 64);
    check("full_ovf_before", int'(bus.overflow_err), 0);
    step(2'b00, 2'b00, 0, 0, 0, 1'b0);
    check("push_ovf_set", int'(bus.overflow_err), 1);
    check("push_ovf_count", int'(bus.free_count), 64);
    step(2'b00, 2'b00, 0, 0, 0, 1'b0);
    check("push_ovf_sticky", int'(bus.overflow_err), 1);
    #1 rst = 1'b1;
    #1;
    check("async_rst2_ovf", int'(bus.overflow_err), 0);
    rst = 1'b0;

    // Steady alloc/free across the wrap point against a FIFO model
    do_reset();
    q.delete();
    for (int t = 32; t < 64; t++) q.push_back(t);
    prev0 = -1;
    prev1 = -1;
    for (int c = 0; c < 40; c++) begin
      fv = (prev0 >= 0) ? 2'b11 : 2'b00;
      step(2'b11, fv, (prev0 >= 0) ? prev0 : 0, (prev1 >= 0) ? prev1 : 0, 0, 1'b0);
      $display("wrap %0d s0=%0d s1=%0d count=%0d", c, slot0(), slot1(), bus.free_count);
      check("wrap_count", int'(bus.free_count), q.size());
      check("wrap_s0", slot0(), q[0]);
      check("wrap_s1", slot1(), q[1]);
      t0 = q.pop_front();
      t1 = q.pop_front();
      if (fv != 2'b00) begin
        q.push_back(prev0);
        q.push_back(prev1);
      end
      prev0 = t0;
      prev1 = t1;
    end
    step(2'b00, 2'b00, 0, 0, 0, 1'b0);
    check("wrap_final_ovf", int'(bus.overflow_err), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
